pe_row_acc: RTL and testbench
=============================

Name: pe_row_acc

Overview:
- Parametrised successor of the fixed 32-lane PE row.
- One row of N_LANE signed multiply lanes with locally held weights, a fully pipelined binary adder tree, and a multi-beat accumulator for long kernels or channel groups.
- Registers the input slice and forwards it to the next row (systolic pass-through).
- Result valid is driven by a valid pipeline, not a free-running counter.

Parameters:
- N_LANE, 32, lane count; power of 2, >=2.
- DATA_W, 7, signed activation width per lane.
- WGT_W, 7, signed weight width per lane.
- ACC_W, 20, signed accumulator/result width; must be >= DATA_W+WGT_W+log2(N_LANE).
- CNT_W, 8, beat counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- w_load  in  1  latch w_in into weight registers
- w_in  in  N_LANE*WGT_W  packed weights; lane i at [i*WGT_W +: WGT_W]
- in_val  in  1  input beat valid
- in_data  in  N_LANE*DATA_W  packed activations, same packing
- in_last  in  1  final beat of accumulation group; qualified by in_val
- data_out  out  N_LANE*DATA_W  registered in_data to next row
- data_out_val  out  1  data_out valid
- result  out  ACC_W  signed group sum
- result_beats  out  CNT_W  beats accumulated into result
- out_val  out  1  one-cycle pulse, result valid
- sat_flag  out  1  group saturated (optional feature)

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low. All registers clear to 0: weights, products, tree stages, valid pipe, accumulator, counter, all outputs.
- Weights: on w_load, weight_reg <= w_in at the clock edge. A beat with in_val in the same cycle uses the OLD weights. New weights apply to beats presented on the next cycle. Beats already in flight are unaffected.
- Stage 0 (cycle 1): prod_i <= signed(in_data_i) * signed(weight_reg_i), width DATA_W+WGT_W. Capture valid and last bits.
- Tree: log2(N_LANE) registered levels; each level adds pairs and sign-extends by 1 bit. Final sum width is DATA_W+WGT_W+log2(N_LANE).
- Accumulate stage: on tail valid, acc <= (group_open ? acc : 0) + sext(sum) and cnt <= (group_open ? cnt : 0) + 1.
  - On tail last: result <= new acc, result_beats <= new cnt, out_val <= 1, group closes. The next valid beat starts from 0.
- Latency: in_val/in_last to out_val is 2+log2(N_LANE) cycles (7 for N_LANE=32).
- Throughput: one beat per cycle. Gaps in in_val are allowed anywhere. Invalid slots do not touch acc or cnt.
- Outputs: result and result_beats hold until the next out_val. out_val is high for exactly one cycle per group.
- Single-beat group (in_last on first beat): result equals that beat's sum; result_beats = 1.
- Counter: cnt wraps at 2^CNT_W without effect on acc.
- Overflow (feature off): acc wraps two's complement at ACC_W.
- Pass-through: data_out <= in_data and data_out_val <= 1 when in_val, latency 1. When in_val is low, data_out_val <= 0 and data_out holds its last value.
- Reset mid-group: the in-flight group is discarded and no out_val is emitted for it. Weights are cleared, so the host must reload them.

Optional Feature:
- Macro: PE_ROW_SAT_EN.
- Defined: the accumulator adds in ACC_W+1 bits and clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Once clamped, it stays sticky-saturated for the rest of the group. sat_flag is presented with result on out_val and cleared at the start of the next group.
- Undefined: wrap arithmetic; sat_flag tied to 0.

Test Plan (N_LANE=32, DATA_W=7, WGT_W=7, ACC_W=20):
1. Assert rst_n low, then release. -> All outputs 0; out_val stays 0 with no input.
2. w_load all weights=1; next cycle one beat, all data=1, in_last=1. -> out_val at cycle +7, result=32, result_beats=1; data_out_val one cycle after in_val, data_out equal to the input.
3. Weights=-64, data=-64 (product 4096, beat sum 131072), 5 beats with in_last on the 5th. -> Without feature: result=-393216, sat_flag=0. With PE_ROW_SAT_EN: result=524287, sat_flag=1.
4. Weights=2; group A = 3 beats of data=1 with one idle cycle between beats; group B = 1 beat of data=-1, back to back with A. -> A: result=192, beats=3. B: result=-64, beats=1. Both out_val pulses are single-cycle.
5. Weights=1, w_load with weights=3 in the same cycle as a beat of data=1 (in_last), then another beat. -> First result=32, second result=96.
6. Pulse rst_n low mid-way through a 4-beat group. -> No out_val for that group; after reloading weights, a fresh 1-beat group gives the correct result.

Source files
------------

// File: rtl/pe_row_acc.sv
// Row of N_LANE signed MAC lanes: per-lane weights, pipelined adder tree, multi-beat group accumulator.
// Define PE_ROW_SAT_EN for a saturating accumulator with a sticky per-group sat_flag.
module pe_row_acc #(
  parameter int unsigned N_LANE = 32,
  parameter int unsigned DATA_W = 7,
  parameter int unsigned WGT_W  = 7,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_load,
  input  logic [N_LANE*WGT_W-1:0]    w_in,
  input  logic                       in_val,
  input  logic [N_LANE*DATA_W-1:0]   in_data,
  input  logic                       in_last,
  output logic [N_LANE*DATA_W-1:0]   data_out,
  output logic                       data_out_val,
  output logic [ACC_W-1:0]           result,
  output logic [CNT_W-1:0]           result_beats,
  output logic                       out_val,
  output logic                       sat_flag
);

  localparam int unsigned LOG = $clog2(N_LANE);
  localparam int unsigned PW  = DATA_W + WGT_W;
  localparam int unsigned SW  = PW + LOG;

  logic [N_LANE*WGT_W-1:0]  w_q;
  logic [N_LANE*DATA_W-1:0] data_out_q;
  logic                     data_out_val_q;

  // Weight bank and systolic pass-through of the input slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q            <= '0;
      data_out_q     <= '0;
      data_out_val_q <= 1'b0;
    end else begin
      if (w_load) w_q <= w_in;
      if (in_val) data_out_q <= in_data;
      data_out_val_q <= in_val;
    end
  end

  // Level 0 holds lane products; level l holds N_LANE>>l partial sums, one bit wider per level
  for (genvar l = 0; l <= LOG; l++) begin : g_lvl
    localparam int unsigned LW = PW + l;
    localparam int unsigned NE = N_LANE >> l;
    logic signed [LW-1:0] s_q [NE];
    logic                 v_q;
    logic                 last_q;

    if (l == 0) begin : g_leaf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q    <= 1'b0;
          last_q <= 1'b0;
        end else begin
          v_q    <= in_val;
          last_q <= in_val & in_last;
        end
      end
      for (genvar i = 0; i < NE; i++) begin : g_e
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) s_q[i] <= '0;
          else        s_q[i] <= PW'($signed(in_data[i*DATA_W +: DATA_W]))
                              * PW'($signed(w_q[i*WGT_W +: WGT_W]));
        end
      end
    end else begin : g_add
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q    <= 1'b0;
          last_q <= 1'b0;
        end else begin
          v_q    <= g_lvl[l-1].v_q;
          last_q <= g_lvl[l-1].last_q;
        end
      end
      for (genvar i = 0; i < NE; i++) begin : g_e
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) s_q[i] <= '0;
          else        s_q[i] <= LW'(g_lvl[l-1].s_q[2*i]) + LW'(g_lvl[l-1].s_q[2*i+1]);
        end
      end
    end
  end

  logic                    tail_v;
  logic                    tail_last;
  logic signed [SW-1:0]    tail_sum;

  assign tail_v    = g_lvl[LOG].v_q;
  assign tail_last = g_lvl[LOG].last_q;
  assign tail_sum  = g_lvl[LOG].s_q[0];

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, acc_next;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_base, cnt_next;
  logic                    open_q, open_d;
  logic [ACC_W-1:0]        result_q, result_d;
  logic [CNT_W-1:0]        beats_q, beats_d;
  logic                    out_val_q, out_val_d;

`ifdef PE_ROW_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic             sat_acc_q, sat_acc_d, sat_base, sat_next;
  logic             sat_flag_q, sat_flag_d;
  logic [ACC_W:0]   acc_wide;
`endif

  // Group accumulator: a beat arriving while no group is open restarts from zero
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    open_d    = open_q;
    result_d  = result_q;
    beats_d   = beats_q;
    out_val_d = 1'b0;
    acc_base  = open_q ? acc_q : '0;
    cnt_base  = open_q ? cnt_q : '0;
    cnt_next  = cnt_base + CNT_W'(1);
`ifdef PE_ROW_SAT_EN
    sat_acc_d  = sat_acc_q;
    sat_flag_d = sat_flag_q;
    sat_base   = open_q & sat_acc_q;
    sat_next   = sat_base;
    acc_wide   = {acc_base[ACC_W-1], acc_base} + (ACC_W+1)'(tail_sum);
    acc_next   = acc_base;
    // Once clamped the group total is frozen at the rail
    if (!sat_base) begin
      if (acc_wide[ACC_W] != acc_wide[ACC_W-1]) begin
        acc_next = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_next = 1'b1;
      end else begin
        acc_next = acc_wide[ACC_W-1:0];
      end
    end
`else
    acc_next = acc_base + ACC_W'(tail_sum);
`endif
    if (tail_v) begin
      acc_d  = acc_next;
      cnt_d  = cnt_next;
      open_d = !tail_last;
`ifdef PE_ROW_SAT_EN
      sat_acc_d = sat_next;
      if (!open_q) sat_flag_d = 1'b0;
`endif
      if (tail_last) begin
        result_d  = acc_next;
        beats_d   = cnt_next;
        out_val_d = 1'b1;
`ifdef PE_ROW_SAT_EN
        sat_flag_d = sat_next;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      open_q    <= 1'b0;
      result_q  <= '0;
      beats_q   <= '0;
      out_val_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      open_q    <= open_d;
      result_q  <= result_d;
      beats_q   <= beats_d;
      out_val_q <= out_val_d;
    end
  end

`ifdef PE_ROW_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_acc_q  <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      sat_acc_q  <= sat_acc_d;
      sat_flag_q <= sat_flag_d;
    end
  end
  assign sat_flag = sat_flag_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign data_out     = data_out_q;
  assign data_out_val = data_out_val_q;
  assign result       = result_q;
  assign result_beats = beats_q;
  assign out_val      = out_val_q;

endmodule

// File: tb/tb_pe_row_acc.sv
// Scoreboard bench for pe_row_acc at default parameters; expectations come from a behavioural group model.
module tb_pe_row_acc;

  localparam int unsigned N   = 32;
  localparam int unsigned DW  = 7;
  localparam int unsigned WW  = 7;
  localparam int unsigned AW  = 20;
  localparam int unsigned CW  = 8;
  localparam int unsigned LAT = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_load;
  logic [N*WW-1:0]   w_in;
  logic              in_val;
  logic [N*DW-1:0]   in_data;
  logic              in_last;
  logic [N*DW-1:0]   data_out;
  logic              data_out_val;
  logic [AW-1:0]     result;
  logic [CW-1:0]     result_beats;
  logic              out_val;
  logic              sat_flag;

  pe_row_acc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_load       (w_load),
    .w_in         (w_in),
    .in_val       (in_val),
    .in_data      (in_data),
    .in_last      (in_last),
    .data_out     (data_out),
    .data_out_val (data_out_val),
    .result       (result),
    .result_beats (result_beats),
    .out_val      (out_val),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          res;
    int          beats;
    bit          sat;
    int unsigned at;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_bad = 0;

  longint m_acc  = 0;
  int     m_cnt  = 0;
  bit     m_open = 1'b0;
  bit     m_sat  = 1'b0;
  int     m_w    = 0;

`ifdef PE_ROW_SAT_EN
  localparam longint AMAX = (longint'(1) << (AW-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (AW-1));
`else
  function automatic longint wrap_acc(input longint x);
    longint m;
    m = x & ((longint'(1) << AW) - 1);
    if (m >= (longint'(1) << (AW-1))) m = m - (longint'(1) << AW);
    return m;
  endfunction
`endif

  function automatic logic [N*DW-1:0] pack_d(input int v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [N*WW-1:0] pack_w(input int v);
    logic [N*WW-1:0] r;
    for (int i = 0; i < N; i++) r[i*WW +: WW] = WW'(v);
    return r;
  endfunction

  // One clock of stimulus; beats use the weights held before this cycle's load
  task automatic drive(input bit wl, input int w, input bit v, input int d, input bit last);
    exp_t   e;
    longint beat;
    w_load  = wl;
    w_in    = pack_w(w);
    in_val  = v;
    in_data = pack_d(d);
    in_last = last;
    if (v) begin
      beat = longint'(N) * longint'(d) * longint'(m_w);
      if (!m_open) begin
        m_acc = 0;
        m_cnt = 0;
        m_sat = 1'b0;
      end
`ifdef PE_ROW_SAT_EN
      if (!m_sat) begin
        m_acc = m_acc + beat;
        if (m_acc > AMAX) begin
          m_acc = AMAX;
          m_sat = 1'b1;
        end else if (m_acc < AMIN) begin
          m_acc = AMIN;
          m_sat = 1'b1;
        end
      end
`else
      m_acc = wrap_acc(m_acc + beat);
`endif
      m_cnt  = (m_cnt + 1) % (1 << CW);
      m_open = !last;
      if (last) begin
        e.res   = int'(m_acc);
        e.beats = m_cnt;
        e.sat   = m_sat;
        e.at    = cyc + LAT;
        sb.push_back(e);
      end
    end
    if (wl) m_w = w;
    @(negedge clk);
    w_load  = 1'b0;
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    in_data = pack_d(13);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    n_cmp++;
    if (out_val !== 1'b0) begin
      n_bad++;
      $display("FAIL out_val_width: out_val=%b after last pulse, required 0", out_val);
    end
  endtask

  // Result monitor: every out_val pulse must match the oldest pending group
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_val === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_val: pulse with result=%0d at cycle %0d, required no pulse",
                 $signed(result), cyc);
      end else begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (int'($signed(result)) !== mon_e.res) begin
          n_bad++;
          $display("FAIL result: got %0d, required %0d", $signed(result), mon_e.res);
        end
        n_cmp++;
        if (int'(result_beats) !== mon_e.beats) begin
          n_bad++;
          $display("FAIL result_beats: got %0d, required %0d", result_beats, mon_e.beats);
        end
        n_cmp++;
        if (sat_flag !== mon_e.sat) begin
          n_bad++;
          $display("FAIL sat_flag: got %b, required %b", sat_flag, mon_e.sat);
        end
        n_cmp++;
        if (cyc !== mon_e.at) begin
          n_bad++;
          $display("FAIL latency: out_val at cycle %0d, required cycle %0d", cyc, mon_e.at);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    if (result !== '0 || result_beats !== '0 || out_val !== 1'b0 || sat_flag !== 1'b0
        || data_out !== '0 || data_out_val !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: result=%h beats=%h out_val=%b sat=%b dout_val=%b, required all 0",
               tag, result, result_beats, out_val, sat_flag, data_out_val);
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst_n   = 1'b0;
    w_load  = 1'b0;
    w_in    = '0;
    in_val  = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst_n  = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_val === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL idle_out_val: %0d pulses with no input, required 0", pulses);
    end
  endtask

  task automatic test_single_beat();
    drive(1'b1, 1, 1'b0, 0, 1'b0);
    drive(1'b0, 1, 1'b1, 1, 1'b1);
    n_cmp++;
    if (data_out_val !== 1'b1 || data_out !== pack_d(1)) begin
      n_bad++;
      $display("FAIL pass_through: dout_val=%b data_out=%h, required 1 and %h",
               data_out_val, data_out, pack_d(1));
    end
    idle(1);
    n_cmp++;
    if (data_out_val !== 1'b0 || data_out !== pack_d(1)) begin
      n_bad++;
      $display("FAIL pass_through_hold: dout_val=%b data_out=%h, required 0 and %h",
               data_out_val, data_out, pack_d(1));
    end
    wait_drain();
  endtask

  task automatic test_saturate();
    drive(1'b1, -64, 1'b0, 0, 1'b0);
    for (int b = 0; b < 5; b++) drive(1'b0, -64, 1'b1, -64, b == 4);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2, 1'b0, 0, 1'b0);
    drive(1'b0, 2, 1'b1, 1, 1'b0);
    idle(1);
    drive(1'b0, 2, 1'b1, 1, 1'b0);
    idle(1);
    drive(1'b0, 2, 1'b1, 1, 1'b1);
    drive(1'b0, 2, 1'b1, -1, 1'b1);
    wait_drain();
  endtask

  task automatic test_weight_switch();
    drive(1'b1, 1, 1'b0, 0, 1'b0);
    drive(1'b1, 3, 1'b1, 1, 1'b1);
    drive(1'b0, 3, 1'b1, 1, 1'b1);
    wait_drain();
  endtask

  task automatic test_random_groups();
    int w;
    int len;
    w = int'($urandom_range(127)) - 64;
    drive(1'b1, w, 1'b0, 0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      len = int'($urandom_range(6, 1));
      for (int b = 0; b < len; b++) begin
        drive(1'b0, w, 1'b1, int'($urandom_range(127)) - 64, b == len - 1);
        if ($urandom_range(2) == 0) idle(1);
      end
    end
    wait_drain();
  endtask

  task automatic test_cnt_wrap();
    drive(1'b1, 1, 1'b0, 0, 1'b0);
    for (int b = 0; b < 257; b++) drive(1'b0, 1, 1'b1, 1, b == 256);
    wait_drain();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1, 1'b0, 0, 1'b0);
    drive(1'b0, 1, 1'b1, 2, 1'b0);
    drive(1'b0, 1, 1'b1, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rst_n  = 1'b1;
    m_open = 1'b0;
    m_w    = 0;
    drive(1'b0, 0, 1'b1, 2, 1'b0);
    drive(1'b0, 0, 1'b1, 2, 1'b1);
    idle(12);
    wait_drain();
    drive(1'b1, 5, 1'b0, 0, 1'b0);
    drive(1'b0, 5, 1'b1, 2, 1'b1);
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_beat();
    test_saturate();
    test_back_to_back();
    test_weight_switch();
    test_random_groups();
    test_cnt_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
